powlib_sfifo_cnt: RTL and testbench

Synchronous FIFO, next generation of the single-clock powlib FIFO. Stores a full D entries (no sacrificed slot) at any D ≥ 2, not only powers of two. Adds an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush and an optional registered read port. It sits between valid/ready stream stages wherever backpressure, rate matching or occupancy-based flow control is needed.

---
 rtl/powlib_sfifo_cnt_pkg.sv | 9 +
 rtl/powlib_sfifo_cnt_if.sv | 26 ++
 rtl/powlib_cntr.sv | 16 +
 rtl/powlib_dpram.sv | 23 ++
 rtl/powlib_sfifo_cnt_oreg.sv | 29 ++
 rtl/powlib_sfifo_cnt.sv | 93 +++++++++
 tb/tb_powlib_sfifo_cnt.sv | 218 +++++++++++++++++++++
 7 files changed

// File: rtl/powlib_sfifo_cnt_pkg.sv
// Shared helpers for the counted single-clock FIFO family.
package powlib_sfifo_cnt_pkg;

    // Bits needed to index v distinct values; never less than one bit.
    function automatic int powlib_clogb2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/powlib_sfifo_cnt_if.sv
// Stream, flush and occupancy signals between a FIFO and its neighbours.
interface powlib_sfifo_cnt_if #(
    parameter int W  = 16,
    parameter int CW = 4
);
    logic          flush;
    logic [W-1:0]  wrdata;
    logic          wrvld;
    logic          wrrdy;
    logic [W-1:0]  rddata;
    logic          rdvld;
    logic          rdrdy;
    logic [CW-1:0] count;
    logic          afull;
    logic          aempty;

    modport master (
        output flush, wrdata, wrvld, rdrdy,
        input  wrrdy, rddata, rdvld, count, afull, aempty
    );

    modport slave (
        input  flush, wrdata, wrvld, rdrdy,
        output wrrdy, rddata, rdvld, count, afull, aempty
    );
endinterface

// File: rtl/powlib_cntr.sv
// Up counter with synchronous clear taking priority over advance.
module powlib_cntr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     cnt <= '0;
        else if (clr) cnt <= '0;
        else if (adv) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/powlib_dpram.sv
// Simple dual-port RAM: registered write, asynchronous read.
module powlib_dpram
    import powlib_sfifo_cnt_pkg::*;
#(
    parameter int W  = 16,
    parameter int D  = 8,
    parameter int AW = powlib_clogb2(D)
) (
    input  logic          clk,
    input  logic          wr,
    input  logic [AW-1:0] wridx,
    input  logic [W-1:0]  wrdata,
    input  logic [AW-1:0] rdidx,
    output logic [W-1:0]  rddata
);
    logic [W-1:0] mem [0:D-1];

    always_ff @(posedge clk) begin
        if (wr) mem[wridx] <= wrdata;
    end

    assign rddata = mem[rdidx];
endmodule

// File: rtl/powlib_sfifo_cnt_oreg.sv
// One-entry valid/ready output register with flush; refills in the same
// cycle it is drained so the read side sustains one word per clock.
module powlib_sfifo_oreg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_data,
    output logic         out_vld,
    input  logic         out_rdy
);
    assign in_rdy = ~out_vld | out_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (flush) begin
            out_vld  <= 1'b0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld) out_data <= in_data;
        end
    end
endmodule

// File: rtl/powlib_sfifo_cnt.sv
// Single-clock FIFO holding all D RAM entries, with occupancy count,
// almost-full/empty flags, synchronous flush and optional output register.
module powlib_sfifo_cnt
    import powlib_sfifo_cnt_pkg::*;
#(
    parameter int W      = 16,
    parameter int D      = 8,
    parameter int AFULL  = D - 2,
    parameter int AEMPTY = 1,
    parameter int OREG   = 0
) (
    input  logic               clk,
    input  logic               rst,
    powlib_sfifo_cnt_if.slave  bus
);
    localparam int CAP = D + OREG;
    localparam int CW  = powlib_clogb2(CAP + 1);
    localparam int PW  = powlib_clogb2(D);

    logic [PW-1:0] wrptr, rdptr;
    logic [CW-1:0] cnt, ram_cnt;
    logic [W-1:0]  ram_q;
    logic          wr_xfer, rd_xfer, ram_vld, ram_rd;

    // Ready comes from the registered total count only, never from rdrdy.
    assign bus.wrrdy = (cnt != CW'(CAP));
    assign wr_xfer   = bus.wrvld & bus.wrrdy & ~bus.flush;
    assign rd_xfer   = bus.rdvld & bus.rdrdy & ~bus.flush;
    assign ram_vld   = (ram_cnt != '0);

    assign bus.count  = cnt;
    assign bus.afull  = (cnt >= CW'(AFULL));
    assign bus.aempty = (cnt <= CW'(AEMPTY));

    powlib_dpram #(.W(W), .D(D), .AW(PW)) u_ram (
        .clk    (clk),
        .wr     (wr_xfer),
        .wridx  (wrptr),
        .wrdata (bus.wrdata),
        .rdidx  (rdptr),
        .rddata (ram_q)
    );

    powlib_cntr #(.W(PW)) u_wrptr (
        .clk (clk),
        .rst (rst),
        .adv (wr_xfer),
        .clr (bus.flush | (wr_xfer & (wrptr == PW'(D - 1)))),
        .cnt (wrptr)
    );

    powlib_cntr #(.W(PW)) u_rdptr (
        .clk (clk),
        .rst (rst),
        .adv (ram_rd),
        .clr (bus.flush | (ram_rd & (rdptr == PW'(D - 1)))),
        .cnt (rdptr)
    );

    if (OREG != 0) begin : g_oreg
        logic in_rdy;
        powlib_sfifo_oreg #(.W(W)) u_oreg (
            .clk      (clk),
            .rst      (rst),
            .flush    (bus.flush),
            .in_data  (ram_q),
            .in_vld   (ram_vld),
            .in_rdy   (in_rdy),
            .out_data (bus.rddata),
            .out_vld  (bus.rdvld),
            .out_rdy  (bus.rdrdy)
        );
        assign ram_rd = ram_vld & in_rdy & ~bus.flush;
    end else begin : g_direct
        assign bus.rddata = ram_q;
        assign bus.rdvld  = ram_vld;
        assign ram_rd     = rd_xfer;
    end

    // cnt includes the word parked in the output register; ram_cnt does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            ram_cnt <= '0;
        end else if (bus.flush) begin
            cnt     <= '0;
            ram_cnt <= '0;
        end else begin
            cnt     <= cnt + CW'(wr_xfer) - CW'(rd_xfer);
            ram_cnt <= ram_cnt + CW'(wr_xfer) - CW'(ram_rd);
        end
    end
endmodule

// File: tb/tb_powlib_sfifo_cnt.sv
// Directed bench: three FIFO configurations driven with vector tables and
// short hand-written sequences for wrap, full, flush and async reset.
module tb_powlib_sfifo_cnt;

    logic clk;
    logic rst;
    int   ncmp  = 0;
    int   nfail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    powlib_sfifo_cnt_if #(.W(8), .CW(3)) ia ();
    powlib_sfifo_cnt_if #(.W(8), .CW(3)) ib ();
    powlib_sfifo_cnt_if #(.W(8), .CW(3)) ic ();

    powlib_sfifo_cnt #(.W(8), .D(5), .AFULL(3), .AEMPTY(1), .OREG(0)) dut_a (
        .clk(clk), .rst(rst), .bus(ia));
    powlib_sfifo_cnt #(.W(8), .D(4), .AFULL(2), .AEMPTY(1), .OREG(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib));
    powlib_sfifo_cnt #(.W(8), .D(4), .AFULL(2), .AEMPTY(1), .OREG(0)) dut_c (
        .clk(clk), .rst(rst), .bus(ic));

    typedef struct {
        logic       wrvld;
        logic [7:0] wrdata;
        logic       rdrdy;
        logic [2:0] cnt;
        logic       wrrdy;
        logic       rdvld;
        logic       dchk;
        logic [7:0] rddata;
        logic       afull;
        logic       aempty;
    } vec_t;

    vec_t vt [11];

    function automatic vec_t mk(logic wv, logic [7:0] wd, logic rr, logic [2:0] c,
                                logic wy, logic rv, logic dc, logic [7:0] d,
                                logic af, logic ae);
        vec_t v;
        v.wrvld = wv; v.wrdata = wd; v.rdrdy = rr; v.cnt = c; v.wrrdy = wy;
        v.rdvld = rv; v.dchk = dc; v.rddata = d; v.afull = af; v.aempty = ae;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1 table: fill D=5 FIFO to full, hold a 6th write, drain in order.
        vt[0]  = mk(1, 8'h01, 0, 1, 1, 1, 1, 8'h01, 0, 1);
        vt[1]  = mk(1, 8'h02, 0, 2, 1, 1, 1, 8'h01, 0, 0);
        vt[2]  = mk(1, 8'h03, 0, 3, 1, 1, 1, 8'h01, 1, 0);
        vt[3]  = mk(1, 8'h04, 0, 4, 1, 1, 1, 8'h01, 1, 0);
        vt[4]  = mk(1, 8'h05, 0, 5, 0, 1, 1, 8'h01, 1, 0);
        vt[5]  = mk(1, 8'h06, 0, 5, 0, 1, 1, 8'h01, 1, 0);
        vt[6]  = mk(0, 8'h00, 1, 4, 1, 1, 1, 8'h02, 1, 0);
        vt[7]  = mk(0, 8'h00, 1, 3, 1, 1, 1, 8'h03, 1, 0);
        vt[8]  = mk(0, 8'h00, 1, 2, 1, 1, 1, 8'h04, 0, 0);
        vt[9]  = mk(0, 8'h00, 1, 1, 1, 1, 1, 8'h05, 0, 1);
        vt[10] = mk(0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 1);

        rst = 1'b0;
        ia.flush = 0; ia.wrvld = 0; ia.wrdata = 0; ia.rdrdy = 0;
        ib.flush = 0; ib.wrvld = 0; ib.wrdata = 0; ib.rdrdy = 0;
        ic.flush = 0; ic.wrvld = 0; ic.wrdata = 0; ic.rdrdy = 0;
        #3;
        chk("rst_a_count",  int'(ia.count),  0);
        chk("rst_a_wrrdy",  int'(ia.wrrdy),  1);
        chk("rst_a_rdvld",  int'(ia.rdvld),  0);
        chk("rst_a_aempty", int'(ia.aempty), 1);
        chk("rst_a_afull",  int'(ia.afull),  0);
        chk("rst_b_rddata", int'(ib.rddata), 0);
        chk("rst_b_rdvld",  int'(ib.rdvld),  0);
        #9 rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            ia.wrvld = vt[i].wrvld; ia.wrdata = vt[i].wrdata; ia.rdrdy = vt[i].rdrdy;
            step();
            chk($sformatf("v%0d_count", i),  int'(ia.count),  int'(vt[i].cnt));
            chk($sformatf("v%0d_wrrdy", i),  int'(ia.wrrdy),  int'(vt[i].wrrdy));
            chk($sformatf("v%0d_rdvld", i),  int'(ia.rdvld),  int'(vt[i].rdvld));
            chk($sformatf("v%0d_afull", i),  int'(ia.afull),  int'(vt[i].afull));
            chk($sformatf("v%0d_aempty", i), int'(ia.aempty), int'(vt[i].aempty));
            if (vt[i].dchk) chk($sformatf("v%0d_rddata", i), int'(ia.rddata), int'(vt[i].rddata));
        end
        ia.wrvld = 0; ia.rdrdy = 0;

        // Test 2: steady state at count=2, 20 cycles of simultaneous traffic.
        ia.wrvld = 1; ia.wrdata = 8'd0; step();
        ia.wrdata = 8'd1; step();
        chk("ss_pre_count", int'(ia.count), 2);
        for (int i = 0; i < 20; i++) begin
            ia.wrvld = 1; ia.rdrdy = 1; ia.wrdata = 8'(i + 2);
            chk($sformatf("ss%0d_rdvld", i), int'(ia.rdvld), 1);
            chk($sformatf("ss%0d_rddata", i), int'(ia.rddata), i);
            step();
            chk($sformatf("ss%0d_count", i), int'(ia.count), 2);
        end
        ia.wrvld = 0;
        chk("ss_tail0", int'(ia.rddata), 20);
        step();
        chk("ss_tail1", int'(ia.rddata), 21);
        step();
        ia.rdrdy = 0;
        chk("ss_end_count", int'(ia.count), 0);

        // Test 3: OREG=1 latency and full capacity of D+1.
        ib.wrvld = 1; ib.wrdata = 8'hAA; step();
        ib.wrvld = 0;
        chk("or_k_rdvld", int'(ib.rdvld), 0);
        chk("or_k_count", int'(ib.count), 1);
        step();
        chk("or_k1_rdvld",  int'(ib.rdvld),  1);
        chk("or_k1_rddata", int'(ib.rddata), 8'hAA);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("or_fill%0d_wrrdy", j), int'(ib.wrrdy), 1);
            ib.wrvld = 1; ib.wrdata = 8'(8'h10 + j); step();
        end
        ib.wrvld = 0;
        chk("or_full_count", int'(ib.count), 5);
        chk("or_full_wrrdy", int'(ib.wrrdy), 0);
        ib.wrvld = 1; ib.wrdata = 8'hEE; step();
        ib.wrvld = 0;
        chk("or_held_count", int'(ib.count), 5);
        ib.rdrdy = 1;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("or_drain%0d_rdvld", j), int'(ib.rdvld), 1);
            chk($sformatf("or_drain%0d_rddata", j), int'(ib.rddata), (j == 0) ? 8'hAA : 8'h10 + j - 1);
            step();
        end
        ib.rdrdy = 0;
        chk("or_empty_rdvld", int'(ib.rdvld), 0);
        chk("or_empty_count", int'(ib.count), 0);

        // Test 4: full D=4 FIFO with write and read both offered.
        for (int j = 0; j < 4; j++) begin
            ic.wrvld = 1; ic.wrdata = 8'(8'h20 + j); step();
        end
        chk("fl_count4", int'(ic.count), 4);
        chk("fl_wrrdy0", int'(ic.wrrdy), 0);
        ic.wrvld = 1; ic.wrdata = 8'h24; ic.rdrdy = 1;
        chk("fl_head", int'(ic.rddata), 8'h20);
        step();
        chk("fl_count3", int'(ic.count), 3);
        chk("fl_wrrdy1", int'(ic.wrrdy), 1);
        chk("fl_next",   int'(ic.rddata), 8'h21);
        ic.rdrdy = 0;
        step();
        ic.wrvld = 0;
        chk("fl_count4b", int'(ic.count), 4);
        ic.rdrdy = 1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("fl_drain%0d", j), int'(ic.rddata), 8'h21 + j);
            step();
        end
        ic.rdrdy = 0;
        chk("fl_drained", int'(ic.count), 0);

        // Test 5: flush at count=3 with a coincident write.
        for (int j = 0; j < 3; j++) begin
            ic.wrvld = 1; ic.wrdata = 8'(8'h30 + j); step();
        end
        chk("fs_count3", int'(ic.count), 3);
        ic.flush = 1; ic.wrvld = 1; ic.wrdata = 8'h99; step();
        ic.flush = 0; ic.wrvld = 0;
        chk("fs_count",  int'(ic.count),  0);
        chk("fs_rdvld",  int'(ic.rdvld),  0);
        chk("fs_wrrdy",  int'(ic.wrrdy),  1);
        chk("fs_aempty", int'(ic.aempty), 1);
        ic.wrvld = 1; ic.wrdata = 8'h40; step();
        ic.wrvld = 0;
        chk("fs_new_rdvld",  int'(ic.rdvld),  1);
        chk("fs_new_rddata", int'(ic.rddata), 8'h40);
        chk("fs_new_count",  int'(ic.count),  1);
        ic.rdrdy = 1; step();
        ic.rdrdy = 0;
        chk("fs_end_rdvld", int'(ic.rdvld), 0);
        chk("fs_end_count", int'(ic.count), 0);

        // Test 6: asynchronous reset mid-cycle with count=2.
        ia.wrvld = 1; ia.wrdata = 8'h60; step();
        ia.wrdata = 8'h61; step();
        ia.wrvld = 0;
        chk("ar_pre_count", int'(ia.count), 2);
        #3 rst = 1'b0;
        #1;
        chk("ar_count",  int'(ia.count),  0);
        chk("ar_rdvld",  int'(ia.rdvld),  0);
        chk("ar_aempty", int'(ia.aempty), 1);
        chk("ar_wrrdy",  int'(ia.wrrdy),  1);
        #2 rst = 1'b1;
        step();
        ia.wrvld = 1; ia.wrdata = 8'h70; step();
        ia.wrvld = 0;
        chk("ar_post_rddata", int'(ia.rddata), 8'h70);
        chk("ar_post_count",  int'(ia.count),  1);
        ia.rdrdy = 1; step();
        ia.rdrdy = 0;
        chk("ar_post_empty", int'(ia.count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
